// File: rtl/mlp_energy_classifier.sv
// Two-stage fixed-weight MLP classifier: 8x4b features -> 3 ReLU hidden -> 3 scores -> argmax.
// Optional build macro APPROX_ARGMAX_EN makes the argmax compare scores with 2 LSBs dropped.
module mlp_energy_classifier #(
    parameter int NUM_A    = 8,
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [NUM_A*WIDTH_A-1:0]   inp,
    output logic                       out_valid,
    output logic [OUTWIDTH-1:0]        out
);

`ifdef APPROX_ARGMAX_EN
    localparam int CW = 6;
`else
    localparam int CW = 8;
`endif

    logic [NUM_A*WIDTH_A-1:0] a_q;
    logic                     v1_q;
    logic [OUTWIDTH-1:0]      out_q;
    logic                     out_valid_q;

    logic signed [6:0]    pre_s [3];
    logic [5:0]           h_s   [3];
    logic signed [7:0]    sc_s  [3];
    logic signed [7:0]    sh_s  [3];
    logic signed [CW-1:0] cmp_s [3];
    logic signed [CW-1:0] best_lo_s;
    logic [OUTWIDTH-1:0]  idx_lo_s;
    logic [OUTWIDTH-1:0]  cls_d;

    function automatic logic signed [6:0] feat(input logic [NUM_A*WIDTH_A-1:0] v, input int idx);
        return $signed({3'b000, v[idx*WIDTH_A +: WIDTH_A]});
    endfunction

    function automatic logic [5:0] relu7(input logic signed [6:0] x);
        logic [5:0] r;
        if (x[6]) begin
            r = 6'd0;
        end else begin
            r = x[5:0];
        end
        return r;
    endfunction

    // Hidden layer, output scores and comparison operands from the stage-1 registers.
    always_comb begin
        pre_s[0] = feat(a_q, 0) + feat(a_q, 1) - feat(a_q, 2);
        pre_s[1] = feat(a_q, 3) + feat(a_q, 4) - feat(a_q, 5);
        pre_s[2] = feat(a_q, 6) + feat(a_q, 7) - feat(a_q, 0);
        for (int k = 0; k < 3; k++) begin
            h_s[k] = relu7(pre_s[k]);
        end
        sc_s[0] = $signed({1'b0, h_s[0], 1'b0}) - $signed({2'b00, h_s[1]});
        sc_s[1] = $signed({1'b0, h_s[1], 1'b0}) - $signed({2'b00, h_s[2]});
        sc_s[2] = $signed({1'b0, h_s[2], 1'b0}) - $signed({2'b00, h_s[0]});
        for (int k = 0; k < 3; k++) begin
`ifdef APPROX_ARGMAX_EN
            sh_s[k]  = sc_s[k] >>> 2;
            cmp_s[k] = sh_s[k][CW-1:0];
`else
            sh_s[k]  = sc_s[k];
            cmp_s[k] = sh_s[k];
`endif
        end
    end

    // Strict-greater argmax so that ties keep the lower index.
    always_comb begin
        idx_lo_s  = (cmp_s[1] > cmp_s[0]) ? 2'd1 : 2'd0;
        best_lo_s = (cmp_s[1] > cmp_s[0]) ? cmp_s[1] : cmp_s[0];
        cls_d     = (cmp_s[2] > best_lo_s) ? 2'd2 : idx_lo_s;
    end

    // Two pipeline stages; the class output only updates on a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            v1_q        <= 1'b0;
            out_q       <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= in_valid;
            out_valid_q <= v1_q;
            if (in_valid) begin
                a_q <= inp;
            end else begin
                a_q <= a_q;
            end
            if (v1_q) begin
                out_q <= cls_d;
            end else begin
                out_q <= out_q;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mlp_energy_classifier.sv
// Scoreboard bench for mlp_energy_classifier: driver queues hand-computed classes, monitor checks.
module tb_mlp_energy_classifier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inp;
    logic        out_valid;
    logic [1:0]  out;

    logic [1:0]  exp_q [$];
    int          n_vec;
    int          n_err;

    mlp_energy_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp       (inp),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] v, input logic [1:0] e);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        inp      = v;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inp      = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every valid result is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got out=%0d expected no result", out);
            end else begin
                check("class", int'(out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inp      = 32'h0;
        #12;
        check("reset_out", out, 0);
        check("reset_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h0000_0000, 2'd0);   // all-zero: three-way tie
        drive(32'h0000_00FF, 2'd0);   // s=(60,0,-30)
        idle();
        drain();

        drive(32'h0005_A000, 2'd1);   // s=(-15,30,0)
        drive(32'h8800_0000, 2'd2);   // s=(0,-16,32)
`ifdef APPROX_ARGMAX_EN
        drive(32'h0000_3004, 2'd0);   // s=(5,6,-4): shifted tie 1,1
`else
        drive(32'h0000_3004, 2'd1);   // s=(5,6,-4)
`endif
        drive(32'h0200_3000, 2'd1);   // s=(-3,4,4): tie s1,s2
        drive(32'h0500_0002, 2'd0);   // s=(4,-3,4): tie s0,s2
        drive(32'hFFFF_FFFF, 2'd0);   // s=(15,15,15)
        drive(32'h0000_0F00, 2'd0);   // all hidden clamp to 0
        idle();
        drain();

        // Back-to-back then idle: out must hold the last class.
        drive(32'h0000_00FF, 2'd0);
        drive(32'h0005_A000, 2'd1);
        idle();
        drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 0);
            check("hold_out", out, 1);
        end

        // Reset with a vector in flight: it must be discarded.
        drive(32'h8800_0000, 2'd2);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_out", out, 0);
        check("midreset_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_valid", out_valid, 0);
            check("post_reset_out", out, 0);
        end
        drive(32'h0005_A000, 2'd1);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
